// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
//   Receive side of a 4-digit multiplexed 7-segment bus. Each {an,seg} pair must
//   be stable for STABLE_CYCLES consecutive samples before it is accepted. An
//   accepted pair is decoded back to a hex nibble and stored per digit.
//
// Parameters
//   STABLE_CYCLES  consecutive equal samples needed to accept {an,seg} (>=1)
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-high
//   seg         in   7  segments {a,b,c,d,e,f,g}, a=bit6, active-high
//   an          in   4  digit enables, active-low; an[N]=0 selects digitN
//   digit0..3   out  4  last decoded hex value of each digit
//   valid       out  4  valid[N]=1: digitN holds a good decode
//   upd         out  1  1-cycle pulse: a digit was decoded successfully
//   err         out  1  1-cycle pulse: bad pattern on a selected digit
//   frame_done  out  1  1-cycle pulse: all 4 digits accepted since last pulse
// -----------------------------------------------------------------------------
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic       upd,
    output logic       err,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [10:0]   r;
    logic [CW-1:0] cnt;
    logic [3:0]    seen;
    logic [3:0]    dig [4];

    logic [10:0]   sample;
    logic          same;
    logic          accept;
    logic          onehot;
    logic [1:0]    idx;
    logic [3:0]    sel_mask;
    logic          hit;
    logic [3:0]    value;
    logic          blank;
    logic [3:0]    seen_next;

    // Segment pattern to hex nibble; hit=0 for patterns outside the table.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] d;
        case (s)
            7'h7E:   d = {1'b1, 4'h0};
            7'h30:   d = {1'b1, 4'h1};
            7'h6D:   d = {1'b1, 4'h2};
            7'h79:   d = {1'b1, 4'h3};
            7'h33:   d = {1'b1, 4'h4};
            7'h5B:   d = {1'b1, 4'h5};
            7'h5F:   d = {1'b1, 4'h6};
            7'h70:   d = {1'b1, 4'h7};
            7'h7F:   d = {1'b1, 4'h8};
            7'h7B:   d = {1'b1, 4'h9};
            7'h77:   d = {1'b1, 4'hA};
            7'h1F:   d = {1'b1, 4'hB};
            7'h4E:   d = {1'b1, 4'hC};
            7'h3D:   d = {1'b1, 4'hD};
            7'h4F:   d = {1'b1, 4'hE};
            7'h47:   d = {1'b1, 4'hF};
            default: d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        sample = {an, seg};
        same   = (sample == r);
        // Fires only on the CNT_LAST -> CNT_MAX step; saturation blocks repeats.
        accept = same && (cnt == CNT_LAST);

        // The accepted pair equals r, so decode from r.
        onehot = 1'b1;
        idx    = 2'd0;
        case (r[10:7])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
        sel_mask = 4'b0001 << idx;

        {hit, value} = decode(r[6:0]);
        blank        = (r[6:0] == 7'h00);
        seen_next    = seen | sel_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= {4'hF, 7'h00};
            cnt        <= '0;
            seen       <= '0;
            valid      <= '0;
            upd        <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                dig[i] <= '0;
            end
        end else begin
            r          <= sample;
            upd        <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;

            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (accept && onehot) begin
                if (hit || blank) begin
                    if (hit) begin
                        dig[idx]   <= value;
                        valid[idx] <= 1'b1;
                        upd        <= 1'b1;
                    end else begin
                        valid[idx] <= 1'b0;
                    end
                    // A completed frame restarts from an empty mask, dropping
                    // the digit that completed it.
                    if (seen_next == 4'hF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen       <= seen_next;
                    end
                end else begin
                    err        <= 1'b1;
                    valid[idx] <= 1'b0;
                end
            end
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];

endmodule

// File: tb/tb_seg7_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_capture
//   Bench for seg7_capture (STABLE_CYCLES=4). A reference model driven by the
//   stimulus predicts each pulse and the digit/valid state at that edge; a
//   separate monitor pops and compares whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_seg7_capture;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h00;
    logic [3:0] an  = 4'hF;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] valid;
    logic       upd, err, frame_done;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .valid      (valid),
        .upd        (upd),
        .err        (err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int unsigned edge_no;
        logic        upd;
        logic        err;
        logic        fd;
        logic [15:0] digs;
        logic [3:0]  valid;
    } exp_t;

    exp_t q[$];

    int unsigned nchecks = 0;
    int unsigned nfail   = 0;
    bit          armed   = 0;

    // Reference model state
    logic [6:0]  tbl [16];
    logic [3:0]  mdig [4];
    logic [3:0]  mvalid;
    logic [3:0]  mseen;
    logic [10:0] last;
    int unsigned run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mdigs();
        return {mdig[3], mdig[2], mdig[1], mdig[0]};
    endfunction

    // Applies the rules for one sampled pair at the upcoming edge.
    task automatic model_edge(input logic r_, input logic [10:0] smp);
        int    zeros;
        int    n;
        int    v;
        exp_t  e;
        if (r_) begin
            for (int i = 0; i < 4; i++) mdig[i] = '0;
            mvalid = '0;
            mseen  = '0;
            last   = {4'hF, 7'h00};
            run    = 1;
            return;
        end
        if (smp == last) begin
            if (run < 1000) run++;
        end else begin
            last = smp;
            run  = 1;
        end
        if (run != S + 1) return;

        zeros = 0;
        n     = 0;
        for (int i = 0; i < 4; i++) begin
            if (!smp[7+i]) begin
                zeros++;
                n = i;
            end
        end
        if (zeros != 1) return;

        v = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == smp[6:0]) v = i;

        e.edge_no = ecount + 1;
        e.upd = 0; e.err = 0; e.fd = 0;
        if (v >= 0 || smp[6:0] == 7'h00) begin
            if (v >= 0) begin
                mdig[n]   = 4'(v);
                mvalid[n] = 1'b1;
                e.upd     = 1;
            end else begin
                mvalid[n] = 1'b0;
            end
            mseen[n] = 1'b1;
            if (mseen == 4'hF) begin
                e.fd  = 1;
                mseen = '0;
            end
        end else begin
            mvalid[n] = 1'b0;
            e.err     = 1;
        end
        e.digs  = mdigs();
        e.valid = mvalid;
        if (e.upd || e.err || e.fd) q.push_back(e);
    endtask

    // One clock of stimulus: check held state, then drive and predict.
    task automatic step(input logic r_, input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        if (armed) begin
            chk("state_digits", {digit3, digit2, digit1, digit0}, mdigs());
            chk("state_valid", valid, mvalid);
        end
        rst = r_;
        an  = a;
        seg = s;
        model_edge(r_, {a, s});
        if (r_) armed = 1;
    endtask

    task automatic hold(input int unsigned nc, input logic [3:0] a, input logic [6:0] s);
        for (int unsigned i = 0; i < nc; i++) step(1'b0, a, s);
    endtask

    // Monitor: compare against the scoreboard whenever the DUT pulses.
    always @(negedge clk) begin
        if (armed) begin
            while (q.size() > 0 && q[0].edge_no < ecount) begin
                exp_t m;
                m = q.pop_front();
                chk("missed_pulse_edge", 0, m.edge_no);
            end
            if (upd === 1'b1 || err === 1'b1 || frame_done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {upd, err, frame_done}, 3'b000);
                end else begin
                    exp_t m;
                    m = q.pop_front();
                    chk("pulse_edge", ecount, m.edge_no);
                    chk("upd", upd, m.upd);
                    chk("err", err, m.err);
                    chk("frame_done", frame_done, m.fd);
                    chk("pulse_digits", {digit3, digit2, digit1, digit0}, m.digs);
                    chk("pulse_valid", valid, m.valid);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

        // Reset held 2 cycles with a decodable pattern present
        step(1'b1, 4'b1110, 7'h7F);
        step(1'b1, 4'b1110, 7'h7F);
        step(1'b0, 4'b1110, 7'h79);
        chk("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        chk("reset_valid", valid, 4'h0);
        chk("reset_pulses", {upd, err, frame_done}, 3'b000);

        // Basic accept then 20 further stable cycles
        hold(24, 4'b1110, 7'h79);
        chk("basic_digit0", digit0, 4'h3);
        chk("basic_valid0", valid[0], 1'b1);

        // Glitch: short 6D window never accepted
        hold(3, 4'b1101, 7'h6D);
        hold(6, 4'b1101, 7'h4F);
        chk("glitch_digit1", digit1, 4'hE);

        // Full frame
        hold(6, 4'b0111, 7'h47);
        hold(6, 4'b1011, 7'h3D);
        hold(6, 4'b1101, 7'h1F);
        hold(6, 4'b1110, 7'h30);
        step(1'b0, 4'b1111, 7'h00);
        chk("frame_digits", {digit3, digit2, digit1, digit0}, 16'hFDB1);
        chk("frame_valid", valid, 4'hF);

        // Error then blank on digit2
        hold(6, 4'b1011, 7'h7F);
        hold(6, 4'b1011, 7'h01);
        chk("err_digit2", digit2, 4'h8);
        chk("err_valid2", valid[2], 1'b0);
        hold(6, 4'b1011, 7'h00);
        chk("blank_valid2", valid[2], 1'b0);

        // Illegal enables
        hold(10, 4'b1100, 7'h30);
        hold(10, 4'b1111, 7'h30);

        // Reset at cnt=2, then a fresh window
        hold(3, 4'b1110, 7'h5B);
        step(1'b1, 4'b1110, 7'h5B);
        hold(3, 4'b1110, 7'h5B);
        chk("rst_mid_digit0", digit0, 4'h0);
        chk("rst_mid_valid", valid, 4'h0);
        hold(4, 4'b1110, 7'h5B);
        chk("rst_fresh_digit0", digit0, 4'h5);

        // Randomized scanning
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  a;
            logic [6:0]  s;
            int unsigned p;
            if ($urandom_range(0, 39) == 0) begin
                step(1'b1, 4'($urandom), 7'($urandom));
            end
            p = $urandom_range(0, 9);
            if (p < 7) a = ~(4'b0001 << $urandom_range(0, 3));
            else       a = 4'($urandom);
            p = $urandom_range(0, 9);
            if (p < 7)       s = tbl[$urandom_range(0, 15)];
            else if (p == 7) s = 7'h00;
            else             s = 7'($urandom);
            hold($urandom_range(1, 7), a, s);
        end

        hold(8, 4'b1111, 7'h00);
        step(1'b0, 4'b1111, 7'h00);
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
